exc_ctrl: RTL and testbench

- Exception/interrupt controller for the single-cycle MIPS datapath.
- Decides when the PC register must leave the normal flow to the illegal-op vector (0x80000004) or the interrupt vector (0x80000008). Drives the PC-select override and the EPC write into $k0 ($26).
- Tracks user/kernel residency, latches and prioritises peripheral interrupts, and re-arms on the return jump (jr $k0).

---
 rtl/exc_ctrl.sv | 72 +++++++
 tb/tb_exc_ctrl.sv | 138 +++++++++++++
 2 files changed

// File: rtl/exc_ctrl.sv
// exc_ctrl: exception/interrupt PC-redirect controller for the single-cycle MIPS datapath
module exc_ctrl #(
    parameter int NIRQ = 4,
    parameter logic [2:0] ILLOP_SEL = 3'd4,
    parameter logic [2:0] XADR_SEL = 3'd5
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [31:0]     pc,
    input  logic [NIRQ-1:0] irq_in,
    input  logic            illop,
    input  logic            eret,
    input  logic            mask_we,
    input  logic [NIRQ-1:0] mask_wdata,
    output logic [2:0]      exc_sel,
    output logic            epc_we,
    output logic [31:0]     epc,
    output logic [2:0]      irq_id,
    output logic [7:0]      cause
);
    typedef enum logic [1:0] {USER = 2'd0, K_IRQ = 2'd1, K_EXC = 2'd2} st_t;
    localparam int PW = NIRQ < 4 ? NIRQ : 4;
    st_t st, st_n;
    logic [NIRQ-1:0] pend, pend_n, mask, clr;
    logic guard, guard_n, fatal, fatal_n, last_illop, last_n;
    logic take_ill, take_irq;
    logic [2:0] low_id;
    logic [3:0] p4;
    assign take_ill = illop && !pc[31];
    assign take_irq = |pend && !pc[31] && !guard && !illop;
    always_comb begin
        low_id = 3'd0;
        for (int i = NIRQ - 1; i >= 0; i--)
            if (pend[i]) low_id = 3'(i);
    end
    assign exc_sel = take_ill ? ILLOP_SEL : take_irq ? XADR_SEL : 3'd0;
    assign epc_we = take_ill || take_irq;
    assign epc = take_ill ? {pc[31], pc[30:0] + 31'd4} : take_irq ? pc : 32'd0;
    assign irq_id = take_irq ? low_id : 3'd0;
    assign clr = take_irq ? NIRQ'(1) << low_id : '0;
    always_comb begin
        pend_n = (pend | (irq_in & mask)) & ~clr;
        st_n = take_ill ? K_EXC : take_irq ? K_IRQ :
               ((st != USER && eret) || !pc[31]) ? USER : st;
        last_n = take_ill ? 1'b1 : take_irq ? 1'b0 : last_illop;
        fatal_n = fatal || (illop && pc[31]);
        // Guard blocks interrupts until one user instruction retires after a return
        guard_n = (st != USER && eret) ? 1'b1 :
                  (st == USER && !pc[31] && !eret) ? 1'b0 : guard;
        p4 = 4'd0;
        for (int i = 0; i < PW; i++) p4[i] = pend_n[i];
    end
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            st <= USER;
            pend <= '0;
            mask <= '1;
            guard <= 1'b0;
            fatal <= 1'b0;
            last_illop <= 1'b0;
            cause <= 8'd0;
        end else begin
            st <= st_n;
            pend <= pend_n;
            mask <= mask_we ? mask_wdata : mask;
            guard <= guard_n;
            fatal <= fatal_n;
            last_illop <= last_n;
            cause <= {fatal_n, st_n, last_n, p4};
        end
    end
endmodule

// File: tb/tb_exc_ctrl.sv
// tb_exc_ctrl: directed checks of exc_ctrl redirect, priority, guard, mask and reset behaviour
module tb_exc_ctrl;
    logic clk = 1'b0, reset = 1'b0;
    logic [31:0] pc = 32'h10;
    logic [3:0] irq_in = 4'd0, mask_wdata = 4'd0;
    logic illop = 1'b0, eret = 1'b0, mask_we = 1'b0;
    logic [2:0] exc_sel, irq_id;
    logic epc_we;
    logic [31:0] epc;
    logic [7:0] cause;
    int errors = 0, checks = 0;

    exc_ctrl dut (
        .clk(clk), .reset(reset), .pc(pc), .irq_in(irq_in), .illop(illop), .eret(eret),
        .mask_we(mask_we), .mask_wdata(mask_wdata), .exc_sel(exc_sel), .epc_we(epc_we),
        .epc(epc), .irq_id(irq_id), .cause(cause)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #3;
        chk("rst_sel", 32'(exc_sel), 0);
        chk("rst_we", 32'(epc_we), 0);
        chk("rst_cause", 32'(cause), 32'h00);
        tick; tick;
        reset = 1'b1;
        repeat (5) tick;
        #1;
        chk("idle_sel", 32'(exc_sel), 0);
        chk("idle_cause", 32'(cause), 32'h00);
        pc = 32'h20; illop = 1'b1; #1;
        chk("ill_sel", 32'(exc_sel), 4);
        chk("ill_we", 32'(epc_we), 1);
        chk("ill_epc", epc, 32'h24);
        tick;
        chk("ill_cause", 32'(cause), 32'h50);
        illop = 1'b0; pc = 32'h80000004; tick;
        chk("kexc_cause", 32'(cause), 32'h50);
        eret = 1'b1; pc = 32'h80000010; tick;
        chk("eret_cause", 32'(cause), 32'h10);
        eret = 1'b0; pc = 32'h24; tick;
        pc = 32'h40; irq_in = 4'b0110; #1;
        chk("irq_nolatch", 32'(exc_sel), 0);
        tick;
        irq_in = 4'd0; #1;
        chk("irq_sel", 32'(exc_sel), 5);
        chk("irq_epc", epc, 32'h40);
        chk("irq_id1", 32'(irq_id), 1);
        chk("irq_we", 32'(epc_we), 1);
        tick;
        chk("kirq_cause", 32'(cause), 32'h24);
        pc = 32'h80000008; #1;
        chk("kern_nosel", 32'(exc_sel), 0);
        tick;
        eret = 1'b1; pc = 32'h80000010; #1;
        chk("eret_nosel", 32'(exc_sel), 0);
        tick;
        chk("ret_cause", 32'(cause), 32'h04);
        eret = 1'b0; pc = 32'h44; #1;
        chk("guard_nosel", 32'(exc_sel), 0);
        tick;
        pc = 32'h48; #1;
        chk("irq2_sel", 32'(exc_sel), 5);
        chk("irq2_id", 32'(irq_id), 2);
        chk("irq2_epc", epc, 32'h48);
        tick;
        chk("irq2_cause", 32'(cause), 32'h20);
        eret = 1'b1; pc = 32'h80000010; tick;
        eret = 1'b0; pc = 32'h4c; tick;
        pc = 32'h50; irq_in = 4'b0001; tick;
        irq_in = 4'd0; illop = 1'b1; pc = 32'h54; #1;
        chk("prio_sel", 32'(exc_sel), 4);
        chk("prio_epc", epc, 32'h58);
        tick;
        chk("prio_cause", 32'(cause), 32'h51);
        illop = 1'b0; pc = 32'h80000004; #1;
        chk("prio_kern", 32'(exc_sel), 0);
        tick;
        eret = 1'b1; pc = 32'h80000010; tick;
        chk("prio_ret_cause", 32'(cause), 32'h11);
        eret = 1'b0; pc = 32'h58; #1;
        chk("prio_guard", 32'(exc_sel), 0);
        tick;
        pc = 32'h5c; #1;
        chk("late_sel", 32'(exc_sel), 5);
        chk("late_id", 32'(irq_id), 0);
        chk("late_epc", epc, 32'h5c);
        tick;
        chk("late_cause", 32'(cause), 32'h20);
        eret = 1'b1; pc = 32'h80000010; tick;
        eret = 1'b0; pc = 32'h60; tick;
        pc = 32'h80000100; illop = 1'b1; #1;
        chk("kill_sel", 32'(exc_sel), 0);
        chk("kill_we", 32'(epc_we), 0);
        tick;
        chk("fatal_cause", 32'(cause), 32'h80);
        illop = 1'b0; pc = 32'h64; tick;
        chk("fatal_sticky", 32'(cause), 32'h80);
        pc = 32'h68; mask_we = 1'b1; mask_wdata = 4'b1110; tick;
        mask_we = 1'b0; irq_in = 4'b0001; #1;
        chk("mask_nosel", 32'(exc_sel), 0);
        tick;
        chk("mask_nopend", 32'(cause), 32'h80);
        chk("mask_nosel2", 32'(exc_sel), 0);
        mask_we = 1'b1; mask_wdata = 4'b1111; tick;
        mask_we = 1'b0; #1;
        chk("unmask_lag", 32'(exc_sel), 0);
        tick;
        irq_in = 4'd0; #1;
        chk("unmask_sel", 32'(exc_sel), 5);
        chk("unmask_id", 32'(irq_id), 0);
        tick;
        chk("unmask_cause", 32'(cause), 32'hA0);
        pc = 32'h80000008; tick;
        chk("handler_cause", 32'(cause), 32'hA0);
        #2 reset = 1'b0; pc = 32'h0; #1;
        chk("arst_cause", 32'(cause), 32'h00);
        chk("arst_sel", 32'(exc_sel), 0);
        tick;
        chk("arst_hold", 32'(cause), 32'h00);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
